alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of entries (power of two, 2..16).
REQ-002 SHALL have parameter ROB_W, default 4, ROB tag width.
REQ-003 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 rdy_in  input  1  global ready; low freezes all state.
REQ-006 clear_in  input  1  mispredict flush.
REQ-007 issue_valid  input  1  new instruction from decoder this cycle.
REQ-008 issue_op  input  6  ALU op code (ALU encoding).
REQ-009 issue_vj / issue_vk / issue_imm  input  32 each  operand values and immediate.
REQ-010 issue_qj_busy / issue_qk_busy  input  1 each  operand j/k still pending.
REQ-011 issue_qj / issue_qk  input  ROB_W each  producer tag of pending operand.
REQ-012 issue_rob_id  input  ROB_W  destination ROB tag.
REQ-013 rs_full  output  1  no free entry (combinational from busy bits).
REQ-014 cdb0_valid, cdb0_rob_id, cdb0_value / cdb1_valid, cdb1_rob_id, cdb1_value  input  1, ROB_W, 32  two result broadcast buses (ALU, LSB).
REQ-015 alu_waiting  output  1  dispatch strobe to ALU.
REQ-016 alu_op, alu_vj, alu_vk, alu_imm  output  6, 32, 32, 32  dispatched operands.
REQ-017 alu_finish_rdy, alu_value  input  1, 32  ALU result, one cycle after dispatch.
REQ-018 res_valid, res_rob_id, res_value  output  1, ROB_W, 32  tagged ALU result for the CDB.

Function
REQ-019 Each entry SHALL hold busy, op, vj, vk, qj_busy, qj, qk_busy, qk, imm, rob_id.
REQ-020 Issue: when issue_valid and not rs_full, the lowest-index free entry SHALL be written and set busy at the edge.
REQ-021 Issue while rs_full SHALL be ignored, no state change.
REQ-022 Issue with a pending operand whose tag matches a same-cycle valid CDB SHALL store that CDB value and clear the pending bit.
REQ-023 Wakeup: each busy entry with pending qj/qk matching cdb0 or cdb1 SHALL capture the value and clear the pending bit; cdb0 wins if both match.
REQ-024 Select: ready entry = busy and both pending bits clear; lowest-index ready entry SHALL be dispatched, max one per cycle.
REQ-025 Dispatch SHALL be combinational: alu_waiting=1 and alu_op/vj/vk/imm from the selected entry in the same cycle; otherwise alu_waiting=0 and alu_* =0.
REQ-026 Dispatched entry SHALL be freed at that edge and be reusable by an issue in the following cycle.
REQ-027 An entry written or woken this cycle SHALL NOT be dispatched before the next cycle.
REQ-028 Issue and dispatch in the same cycle SHALL both proceed (distinct entries).
REQ-029 Dispatched rob_id SHALL be registered at the dispatch edge; res_valid=alu_finish_rdy, res_value=alu_value, res_rob_id=that register (latency dispatch->result 1 cycle).
REQ-030 op 6'b111111 SHALL be dispatched normally (ALU yields 0).
REQ-031 clear_in (with rdy_in high) SHALL at the edge clear all busy bits and the rob_id register; issue in that cycle SHALL be dropped; alu_waiting SHALL be 0 while clear_in is high.
REQ-032 rdy_in low SHALL hold all entries and registers; alu_waiting SHALL be 0.

Reset
REQ-033 rst_in low SHALL asynchronously clear all busy/pending bits and the rob_id register; rs_full=0, alu_waiting=0, alu_* =0, res_rob_id=0.
REQ-034 Reset mid-operation SHALL discard all entries; first post-reset issue SHALL go to entry 0.

Verification
REQ-035 Issue addi op, vj=5, imm=3, rob 2, no pending -> next cycle alu_waiting=1, alu_vj=5; cycle after res_valid=1, res_rob_id=2, res_value=8.
REQ-036 Issue add rob 4 with qj_busy, qj=7; later cdb1 rob 7 value 0x10 -> dispatch next cycle with alu_vj=0x10.
REQ-037 Issue with qk=3 while cdb0_valid, rob 3, value 9 same cycle -> entry stored ready, dispatch next cycle with alu_vk=9.
REQ-038 Issue 8 blocked instructions -> rs_full=1; 9th issue ignored; one wakeup+dispatch -> rs_full=0 next cycle.
REQ-039 Fill 3 entries, assert clear_in one cycle -> all entries empty, no dispatch, rs_full=0.
REQ-040 Assert rst_in low mid-cycle with entries busy -> outputs zero immediately, no result emitted after release.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ALU ops until both operands arrive via the CDBs,
// then dispatches the lowest-index ready entry to the ALU and tags the returning result.
module alu_rs #(
   parameter int RS_SIZE = 8,
   parameter int ROB_W   = 4
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clear_in,
   input  logic              issue_valid,
   input  logic [5:0]        issue_op,
   input  logic [31:0]       issue_vj,
   input  logic [31:0]       issue_vk,
   input  logic [31:0]       issue_imm,
   input  logic              issue_qj_busy,
   input  logic              issue_qk_busy,
   input  logic [ROB_W-1:0]  issue_qj,
   input  logic [ROB_W-1:0]  issue_qk,
   input  logic [ROB_W-1:0]  issue_rob_id,
   output logic              rs_full,
   input  logic              cdb0_valid,
   input  logic [ROB_W-1:0]  cdb0_rob_id,
   input  logic [31:0]       cdb0_value,
   input  logic              cdb1_valid,
   input  logic [ROB_W-1:0]  cdb1_rob_id,
   input  logic [31:0]       cdb1_value,
   output logic              alu_waiting,
   output logic [5:0]        alu_op,
   output logic [31:0]       alu_vj,
   output logic [31:0]       alu_vk,
   output logic [31:0]       alu_imm,
   input  logic              alu_finish_rdy,
   input  logic [31:0]       alu_value,
   output logic              res_valid,
   output logic [ROB_W-1:0]  res_rob_id,
   output logic [31:0]       res_value
);

   localparam int DATA_W = 32;
   localparam int IDX_W  = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   logic [RS_SIZE-1:0] r_busy;
   logic [RS_SIZE-1:0] r_qj_busy;
   logic [RS_SIZE-1:0] r_qk_busy;
   logic [5:0]         r_op  [RS_SIZE];
   logic [DATA_W-1:0]  r_vj  [RS_SIZE];
   logic [DATA_W-1:0]  r_vk  [RS_SIZE];
   logic [DATA_W-1:0]  r_imm [RS_SIZE];
   logic [ROB_W-1:0]   r_qj  [RS_SIZE];
   logic [ROB_W-1:0]   r_qk  [RS_SIZE];
   logic [ROB_W-1:0]   r_rob [RS_SIZE];
   logic [ROB_W-1:0]   r_res_rob_p1;

   logic [RS_SIZE-1:0] w_ready;
   logic               w_free_found;
   logic [IDX_W-1:0]   w_free_idx;
   logic               w_sel_found;
   logic [IDX_W-1:0]   w_sel_idx;
   logic               w_issue_go;
   logic               w_disp_go;
   logic [DATA_W:0]    w_fj [RS_SIZE];
   logic [DATA_W:0]    w_fk [RS_SIZE];
   logic [DATA_W:0]    w_ij;
   logic [DATA_W:0]    w_ik;

   // Returns {still_pending, value}; cdb0 takes priority when both buses carry the tag.
   function automatic logic [DATA_W:0] fwd_operand(
      input logic              pend,
      input logic [ROB_W-1:0]  tag,
      input logic [DATA_W-1:0] val,
      input logic              c0_v,
      input logic [ROB_W-1:0]  c0_t,
      input logic [DATA_W-1:0] c0_d,
      input logic              c1_v,
      input logic [ROB_W-1:0]  c1_t,
      input logic [DATA_W-1:0] c1_d
   );
      logic [DATA_W:0] res;
      res = {pend, val};
      if (pend && c0_v && (c0_t == tag)) begin
         res = {1'b0, c0_d};
      end else if (pend && c1_v && (c1_t == tag)) begin
         res = {1'b0, c1_d};
      end
      return res;
   endfunction

   assign rs_full    = &r_busy;
   assign w_ready    = r_busy & ~r_qj_busy & ~r_qk_busy;
   assign w_issue_go = rdy_in && !clear_in && issue_valid && !rs_full;
   assign w_disp_go  = rdy_in && !clear_in && w_sel_found;

   always_comb begin
      w_free_found = 1'b0;
      w_free_idx   = '0;
      w_sel_found  = 1'b0;
      w_sel_idx    = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!r_busy[i]) begin
            w_free_found = 1'b1;
            w_free_idx   = IDX_W'(i);
         end
         if (w_ready[i]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         w_fj[i] = fwd_operand(r_qj_busy[i], r_qj[i], r_vj[i], cdb0_valid, cdb0_rob_id,
                               cdb0_value, cdb1_valid, cdb1_rob_id, cdb1_value);
         w_fk[i] = fwd_operand(r_qk_busy[i], r_qk[i], r_vk[i], cdb0_valid, cdb0_rob_id,
                               cdb0_value, cdb1_valid, cdb1_rob_id, cdb1_value);
      end
      w_ij = fwd_operand(issue_qj_busy, issue_qj, issue_vj, cdb0_valid, cdb0_rob_id,
                         cdb0_value, cdb1_valid, cdb1_rob_id, cdb1_value);
      w_ik = fwd_operand(issue_qk_busy, issue_qk, issue_vk, cdb0_valid, cdb0_rob_id,
                         cdb0_value, cdb1_valid, cdb1_rob_id, cdb1_value);
   end

   // Stage p0: combinational select and dispatch to the ALU
   always_comb begin
      alu_waiting = 1'b0;
      alu_op      = '0;
      alu_vj      = '0;
      alu_vk      = '0;
      alu_imm     = '0;
      if (w_disp_go) begin
         alu_waiting = 1'b1;
         alu_op      = r_op[w_sel_idx];
         alu_vj      = r_vj[w_sel_idx];
         alu_vk      = r_vk[w_sel_idx];
         alu_imm     = r_imm[w_sel_idx];
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_busy       <= '0;
         r_qj_busy    <= '0;
         r_qk_busy    <= '0;
         r_res_rob_p1 <= '0;
      end else if (rdy_in) begin
         if (clear_in) begin
            r_busy       <= '0;
            r_res_rob_p1 <= '0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (r_busy[i]) begin
                  r_qj_busy[i] <= w_fj[i][DATA_W];
                  r_qk_busy[i] <= w_fk[i][DATA_W];
               end
            end
            if (w_disp_go) begin
               r_busy[w_sel_idx] <= 1'b0;
               r_res_rob_p1      <= r_rob[w_sel_idx];
            end
            if (w_issue_go) begin
               r_busy[w_free_idx]    <= 1'b1;
               r_qj_busy[w_free_idx] <= w_ij[DATA_W];
               r_qk_busy[w_free_idx] <= w_ik[DATA_W];
            end
         end
      end
   end

   // Entry payload carries no reset; busy/pending bits decide whether it means anything.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !clear_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (r_busy[i]) begin
               r_vj[i] <= w_fj[i][DATA_W-1:0];
               r_vk[i] <= w_fk[i][DATA_W-1:0];
            end
         end
         if (w_issue_go) begin
            r_op[w_free_idx]  <= issue_op;
            r_vj[w_free_idx]  <= w_ij[DATA_W-1:0];
            r_vk[w_free_idx]  <= w_ik[DATA_W-1:0];
            r_imm[w_free_idx] <= issue_imm;
            r_qj[w_free_idx]  <= issue_qj;
            r_qk[w_free_idx]  <= issue_qk;
            r_rob[w_free_idx] <= issue_rob_id;
         end
      end
   end

   // Stage p1: ALU result returns one cycle after dispatch, tagged with the latched rob id
   assign res_valid  = alu_finish_rdy;
   assign res_value  = alu_value;
   assign res_rob_id = r_res_rob_p1;

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a behavioural RS model predicts dispatches and results,
// a negedge monitor compares them against the DUT; a small fake ALU closes the loop.
module tb_alu_rs;
   localparam int RS = 8;
   localparam int RW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b1;
   logic rdy, clr, iv, iqjb, iqkb;
   logic [5:0] iop;
   logic [31:0] ivj, ivk, iimm;
   logic [RW-1:0] iqj, iqk, irob;
   logic full;
   logic c0v, c1v;
   logic [RW-1:0] c0t, c1t;
   logic [31:0] c0d, c1d;
   logic aw;
   logic [5:0] aop;
   logic [31:0] avj, avk, aimm;
   logic afin;
   logic [31:0] aval;
   logic rv;
   logic [RW-1:0] rrob;
   logic [31:0] rval;

   alu_rs #(.RS_SIZE(RS), .ROB_W(RW)) dut (
      .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .clear_in(clr),
      .issue_valid(iv), .issue_op(iop), .issue_vj(ivj), .issue_vk(ivk), .issue_imm(iimm),
      .issue_qj_busy(iqjb), .issue_qk_busy(iqkb), .issue_qj(iqj), .issue_qk(iqk),
      .issue_rob_id(irob), .rs_full(full),
      .cdb0_valid(c0v), .cdb0_rob_id(c0t), .cdb0_value(c0d),
      .cdb1_valid(c1v), .cdb1_rob_id(c1t), .cdb1_value(c1d),
      .alu_waiting(aw), .alu_op(aop), .alu_vj(avj), .alu_vk(avk), .alu_imm(aimm),
      .alu_finish_rdy(afin), .alu_value(aval),
      .res_valid(rv), .res_rob_id(rrob), .res_value(rval)
   );

   // Fake ALU: answers one cycle after each dispatch; op 0x3f yields zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         afin <= 1'b0;
         aval <= '0;
      end else begin
         afin <= aw;
         aval <= (aop == 6'h3f) ? 32'h0 : (avj + avk + aimm);
      end
   end

   typedef struct {
      logic busy; logic [5:0] op; logic [31:0] vj, vk, imm;
      logic qjb, qkb; logic [RW-1:0] qj, qk, rob;
   } ent_t;
   typedef struct { logic [5:0] op; logic [31:0] vj, vk, imm; } disp_t;
   typedef struct { logic [RW-1:0] rob; logic [31:0] val; } res_t;

   ent_t  m [RS];
   disp_t exp_disp [$];
   res_t  exp_res [$];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] alu_fn(input ent_t e);
      return (e.op == 6'h3f) ? 32'h0 : (e.vj + e.vk + e.imm);
   endfunction

   function automatic int m_sel();
      for (int i = 0; i < RS; i++)
         if (m[i].busy && !m[i].qjb && !m[i].qkb) return i;
      return -1;
   endfunction

   function automatic int m_free();
      for (int i = 0; i < RS; i++)
         if (!m[i].busy) return i;
      return -1;
   endfunction

   task automatic fwd(input logic pend, input logic [RW-1:0] tag, input logic [31:0] v,
                      output logic npend, output logic [31:0] nv);
      npend = pend;
      nv = v;
      if (pend && c0v && c0t == tag) begin npend = 1'b0; nv = c0d; end
      else if (pend && c1v && c1t == tag) begin npend = 1'b0; nv = c1d; end
   endtask

   task automatic model_reset();
      for (int i = 0; i < RS; i++) begin
         m[i].busy = 1'b0; m[i].qjb = 1'b0; m[i].qkb = 1'b0;
      end
      exp_disp.delete();
      exp_res.delete();
   endtask

   // One clock: predict this cycle's dispatch, then advance the model at the edge.
   task automatic cycle();
      int sel, fr;
      bit full_now;
      ent_t e;
      #1;
      fr = m_free();
      full_now = (fr < 0);
      chk("rs_full", full, full_now);
      sel = (rdy && !clr) ? m_sel() : -1;
      if (sel >= 0) exp_disp.push_back('{m[sel].op, m[sel].vj, m[sel].vk, m[sel].imm});
      @(posedge clk);
      if (rdy) begin
         if (clr) begin
            for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
         end else begin
            for (int i = 0; i < RS; i++) begin
               if (m[i].busy) begin
                  fwd(m[i].qjb, m[i].qj, m[i].vj, m[i].qjb, m[i].vj);
                  fwd(m[i].qkb, m[i].qk, m[i].vk, m[i].qkb, m[i].vk);
               end
            end
            if (sel >= 0) begin
               exp_res.push_back('{m[sel].rob, alu_fn(m[sel])});
               m[sel].busy = 1'b0;
            end
            if (iv && !full_now) begin
               e.busy = 1'b1; e.op = iop; e.imm = iimm; e.rob = irob;
               e.qj = iqj; e.qk = iqk;
               fwd(iqjb, iqj, ivj, e.qjb, e.vj);
               fwd(iqkb, iqk, ivk, e.qkb, e.vk);
               m[fr] = e;
            end
         end
      end
      #1;
   endtask

   task automatic set_idle();
      rdy = 1'b1; clr = 1'b0; iv = 1'b0; iop = '0; ivj = '0; ivk = '0; iimm = '0;
      iqjb = 1'b0; iqkb = 1'b0; iqj = '0; iqk = '0; irob = '0;
      c0v = 1'b0; c0t = '0; c0d = '0; c1v = 1'b0; c1t = '0; c1d = '0;
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] imm, input logic qjb, input logic [RW-1:0] qj,
                        input logic qkb, input logic [RW-1:0] qk, input logic [RW-1:0] rob);
      iv = 1'b1; iop = op; ivj = vj; ivk = vk; iimm = imm;
      iqjb = qjb; iqj = qj; iqkb = qkb; iqk = qk; irob = rob;
   endtask

   task automatic async_reset_mid();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rs_full", full, 0);
      chk("rst_alu_waiting", aw, 0);
      chk("rst_alu_bus", avj | avk | aimm | 32'(aop), 0);
      chk("rst_res_rob_id", rrob, 0);
      chk("rst_res_valid", rv, 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Monitor: pops expectations whenever the DUT dispatches or returns a result.
   always @(negedge clk) begin : monitor
      disp_t d;
      res_t r;
      if (rst_n === 1'b1) begin
         if (aw === 1'b1) begin
            if (exp_disp.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_dispatch: got op=%h vj=%h expected none", aop, avj);
            end else begin
               d = exp_disp.pop_front();
               chk("disp_op", 32'(aop), 32'(d.op));
               chk("disp_vj", avj, d.vj);
               chk("disp_vk", avk, d.vk);
               chk("disp_imm", aimm, d.imm);
            end
         end else begin
            chk("idle_alu_bus", avj | avk | aimm | 32'(aop), 0);
         end
         if (rv === 1'b1) begin
            if (exp_res.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_result: got rob=%h val=%h expected none", rrob, rval);
            end else begin
               r = exp_res.pop_front();
               chk("res_rob_id", 32'(rrob), 32'(r.rob));
               chk("res_value", rval, r.val);
            end
         end
      end
   end

   initial begin
      set_idle();
      for (int i = 0; i < RS; i++) m[i] = '{default: '0};
      #1 rst_n = 1'b0;
      #1;
      chk("reset_rs_full", full, 0);
      chk("reset_alu_waiting", aw, 0);
      chk("reset_res_rob_id", rrob, 0);
      chk("reset_alu_bus", avj | avk | aimm | 32'(aop), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // addi vj=5 imm=3 rob 2
      issue(6'h01, 32'd5, 32'd0, 32'd3, 0, 0, 0, 0, 4'd2);
      cycle(); set_idle(); #1;
      chk("addi_waiting", aw, 1);
      chk("addi_vj", avj, 5);
      cycle(); #1;
      chk("addi_res_valid", rv, 1);
      chk("addi_res_rob", 32'(rrob), 2);
      chk("addi_res_value", rval, 8);
      cycle();

      // pending qj woken by cdb1
      issue(6'h00, 32'd0, 32'd1, 32'd0, 1, 4'd7, 0, 0, 4'd4);
      cycle(); set_idle();
      repeat (3) cycle();
      c1v = 1'b1; c1t = 4'd7; c1d = 32'h10;
      cycle(); set_idle(); #1;
      chk("wake_waiting", aw, 1);
      chk("wake_vj", avj, 32'h10);
      repeat (2) cycle();

      // same-cycle cdb0 capture at issue
      issue(6'h00, 32'd2, 32'd0, 32'd0, 0, 0, 1, 4'd3, 4'd5);
      c0v = 1'b1; c0t = 4'd3; c0d = 32'd9;
      cycle(); set_idle(); #1;
      chk("capture_waiting", aw, 1);
      chk("capture_vk", avk, 9);
      repeat (2) cycle();

      // fill with blocked entries, overflow, then free one
      for (int k = 0; k < RS; k++) begin
         issue(6'h02, 32'(k), 32'd1, 32'd0, 1, 4'(k + 8), 0, 0, 4'(k));
         cycle();
      end
      set_idle(); #1;
      chk("full_after_8", full, 1);
      issue(6'h02, 32'd100, 32'd0, 32'd0, 0, 0, 0, 0, 4'd9);
      cycle(); set_idle();
      c0v = 1'b1; c0t = 4'd8; c0d = 32'h55;
      cycle(); set_idle(); #1;
      chk("full_during_dispatch", full, 1);
      chk("full_dispatch_vj", avj, 32'h55);
      cycle(); #1;
      chk("full_freed", full, 0);
      clr = 1'b1;
      cycle(); set_idle();

      // three entries then clear (one ready when clear is asserted)
      issue(6'h03, 32'd1, 32'd1, 32'd0, 1, 4'd12, 0, 0, 4'd1); cycle();
      issue(6'h03, 32'd2, 32'd1, 32'd0, 0, 0, 1, 4'd13, 4'd2); cycle();
      issue(6'h03, 32'd3, 32'd1, 32'd0, 0, 0, 0, 0, 4'd3); cycle();
      set_idle(); clr = 1'b1;
      issue(6'h03, 32'd4, 32'd1, 32'd0, 0, 0, 0, 0, 4'd4);
      #1;
      chk("clear_no_dispatch", aw, 0);
      cycle(); set_idle(); #1;
      chk("clear_rs_full", full, 0);
      chk("clear_empty_no_dispatch", aw, 0);
      c0v = 1'b1; c0t = 4'd12; c1v = 1'b1; c1t = 4'd13;
      cycle(); set_idle(); #1;
      chk("clear_woken_no_dispatch", aw, 0);
      cycle();

      // op 0x3f and rdy low hold
      issue(6'h3f, 32'd7, 32'd0, 32'd1, 0, 0, 0, 0, 4'd6);
      cycle(); set_idle(); rdy = 1'b0;
      issue(6'h01, 32'd1, 32'd0, 32'd1, 0, 0, 0, 0, 4'd7);
      #1;
      chk("rdy_low_no_dispatch", aw, 0);
      repeat (3) cycle();
      set_idle();
      repeat (3) cycle();

      // async reset with entries busy and a result in flight
      issue(6'h01, 32'd10, 32'd0, 32'd1, 0, 0, 0, 0, 4'd8); cycle();
      issue(6'h01, 32'd20, 32'd0, 32'd1, 0, 0, 0, 0, 4'd9); cycle();
      set_idle();
      async_reset_mid();
      repeat (3) cycle();
      issue(6'h01, 32'd30, 32'd0, 32'd2, 0, 0, 0, 0, 4'd10);
      cycle(); set_idle();
      repeat (3) cycle();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         rdy  = ($urandom_range(0, 9) != 0);
         clr  = ($urandom_range(0, 59) == 0);
         iv   = $urandom_range(0, 1);
         iop  = ($urandom_range(0, 7) == 0) ? 6'h3f : 6'($urandom);
         ivj  = $urandom; ivk = $urandom; iimm = $urandom;
         iqjb = ($urandom_range(0, 2) == 0); iqj = 4'($urandom);
         iqkb = ($urandom_range(0, 2) == 0); iqk = 4'($urandom);
         irob = 4'($urandom);
         c0v  = ($urandom_range(0, 2) == 0); c0t = 4'($urandom); c0d = $urandom;
         c1v  = ($urandom_range(0, 2) == 0); c1t = 4'($urandom); c1d = $urandom;
         cycle();
      end
      set_idle();
      repeat (12) cycle();
      chk("drain_disp_queue", exp_disp.size(), 0);
      chk("drain_res_queue", exp_res.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
